// File: rtl/hdmi_capture_core.sv
// HDMI video capture front end: packs ve-qualified pixels into 32-bit FIFO
// words and emits frame/line/chunk markers for the downstream memory writer.
module hdmi_capture_core #(
    parameter int NUM_BYTES_PER_PIXEL = 2,
    parameter int CHUNK_WORDS         = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [10:0] hres,
    input  logic [7:0]  red,
    input  logic [7:0]  green,
    input  logic [7:0]  blue,
    input  logic        hsync,
    input  logic        vsync,
    input  logic        ve,
    input  logic        fifo_full,
    output logic [31:0] fifo_data,
    output logic        write_fifo,
    output logic        write_go,
    output logic        write_next_line,
    output logic        write_next_chunk,
    output logic        write_done,
    output logic        overflow
);
    localparam bit WIDE = (NUM_BYTES_PER_PIXEL == 4);
    localparam int CW   = $clog2(CHUNK_WORDS + 1);

    typedef enum logic [1:0] {IDLE, ARM, FRAME} state_t;
    state_t state, state_nx;

    logic          vsync_d, ve_d, vs_rise, ve_fall;
    logic          go_nx, done_nx, capture, line_end, flush, push_nx, chunk_hit;
    logic [11:0]   pix_cnt;
    logic          pend_vld, nl_pend;
    logic [15:0]   pend_px, px16;
    logic [31:0]   word_nx;
    logic [CW-1:0] chunk_cnt, chunk_inc;
    logic          unused_hsync;

    // Lines are delimited by ve alone; hsync carries no information here.
    assign unused_hsync = hsync;
    assign px16    = {red[7:3], green[7:2], blue[7:3]};
    assign vs_rise = vsync & ~vsync_d;
    assign ve_fall = ve_d & ~ve;

    always_comb begin
        state_nx = state;
        go_nx    = 1'b0;
        done_nx  = 1'b0;
        case (state)
            IDLE:  if (start) state_nx = ARM;
            ARM:   if (vs_rise) begin
                       state_nx = FRAME;
                       go_nx    = 1'b1;
                   end
            FRAME: if (vs_rise) begin
                       done_nx  = 1'b1;
                       state_nx = start ? ARM : IDLE;
                   end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        capture  = (state == FRAME) && ve && !vsync && (pix_cnt < {1'b0, hres});
        line_end = (state == FRAME) && ve_fall && !vs_rise;
        flush    = line_end && pend_vld;
        push_nx  = 1'b0;
        word_nx  = fifo_data;
        if (capture) begin
            if (WIDE) begin
                push_nx = 1'b1;
                word_nx = {8'h00, red, green, blue};
            end else if (pend_vld) begin
                push_nx = 1'b1;
                word_nx = {pend_px, px16};
            end
        end else if (flush) begin
            push_nx = 1'b1;
            word_nx = {pend_px, 16'h0000};
        end
        chunk_inc = chunk_cnt + CW'(1);
        chunk_hit = push_nx && (chunk_inc == CW'(CHUNK_WORDS));
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state            <= IDLE;
            vsync_d          <= 1'b0;
            ve_d             <= 1'b0;
            pix_cnt          <= '0;
            pend_vld         <= 1'b0;
            pend_px          <= '0;
            nl_pend          <= 1'b0;
            chunk_cnt        <= '0;
            fifo_data        <= '0;
            write_fifo       <= 1'b0;
            write_go         <= 1'b0;
            write_next_line  <= 1'b0;
            write_next_chunk <= 1'b0;
            write_done       <= 1'b0;
            overflow         <= 1'b0;
        end else begin
            state            <= state_nx;
            vsync_d          <= vsync;
            ve_d             <= ve;
            write_go         <= go_nx;
            write_done       <= done_nx;
            write_fifo       <= push_nx && !fifo_full;
            write_next_chunk <= chunk_hit;
            // A flushed line reports one cycle later, after its flush word.
            write_next_line  <= nl_pend || (line_end && !pend_vld && pix_cnt != '0);
            nl_pend          <= flush;
            if (push_nx) fifo_data <= word_nx;
            if (go_nx) overflow <= 1'b0;
            else if (push_nx && fifo_full) overflow <= 1'b1;
            if (state_nx != FRAME || line_end) begin
                pix_cnt   <= '0;
                pend_vld  <= 1'b0;
                chunk_cnt <= '0;
            end else begin
                if (capture) begin
                    pix_cnt <= pix_cnt + 12'd1;
                    if (!WIDE) begin
                        pend_vld <= ~pend_vld;
                        pend_px  <= px16;
                    end
                end
                if (push_nx) chunk_cnt <= chunk_hit ? '0 : chunk_inc;
            end
        end
    end
endmodule

// File: tb/tb_hdmi_capture_core.sv
// Bench for hdmi_capture_core: a cycle plan is built up front together with the
// expected output timeline (derived from line lengths), then replayed on 2- and 4-byte DUTs.
module tb_hdmi_capture_core;
    localparam int N       = 3000;
    localparam int CH2     = 4;
    localparam int CH4     = 16;
    localparam int S_IDLE  = 0;
    localparam int S_ARM   = 1;
    localparam int S_FRAME = 2;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset, start, hsync, vsync, ve, fifo_full;
    logic [10:0] hres;
    logic [7:0]  red, green, blue;
    logic [31:0] data2, data4;
    logic        wf2, wf4, go2, go4, nl2, nl4, ch2, ch4, dn2, dn4, ov2, ov4;

    hdmi_capture_core #(.NUM_BYTES_PER_PIXEL(2), .CHUNK_WORDS(CH2)) dut2 (
        .clock(clock), .reset(reset), .start(start), .hres(hres),
        .red(red), .green(green), .blue(blue), .hsync(hsync), .vsync(vsync), .ve(ve),
        .fifo_full(fifo_full), .fifo_data(data2), .write_fifo(wf2), .write_go(go2),
        .write_next_line(nl2), .write_next_chunk(ch2), .write_done(dn2), .overflow(ov2));

    hdmi_capture_core #(.NUM_BYTES_PER_PIXEL(4), .CHUNK_WORDS(CH4)) dut4 (
        .clock(clock), .reset(reset), .start(start), .hres(hres),
        .red(red), .green(green), .blue(blue), .hsync(hsync), .vsync(vsync), .ve(ve),
        .fifo_full(fifo_full), .fifo_data(data4), .write_fifo(wf4), .write_go(go4),
        .write_next_line(nl4), .write_next_chunk(ch4), .write_done(dn4), .overflow(ov4));

    // Input plan per cycle, and expected outputs per cycle (index 0: 2-byte, 1: 4-byte).
    logic        p_rst[N], p_start[N], p_vs[N], p_ve[N], p_full[N], p_hs[N];
    logic [7:0]  p_r[N], p_g[N], p_b[N];
    logic [10:0] p_hres[N];
    logic        e_try[2][N], e_wf[2][N], e_nl[2][N], e_ch[2][N], e_ov[2][N];
    logic [31:0] e_data[2][N];
    logic        e_go[N], e_done[N];

    int          pc, st, full_pct, plan_len;
    logic        cur_start, prev_vs, built;
    logic [10:0] cur_hres;
    int          pin_a, pin_b, pin_40, pin_cdone, pin_go, pin_rst;
    int          checks = 0, failures = 0;

    function automatic logic [15:0] enc16(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        return {r[7:3], g[7:2], b[7:3]};
    endfunction

    task automatic emit(input logic rst, input logic vs, input logic v,
                        input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        if (pc >= N - 4) begin
            $display("FAIL plan_size cyc=%0d limit=%0d", pc, N - 4);
            $fatal(1);
        end
        p_rst[pc] = rst; p_start[pc] = cur_start; p_vs[pc] = vs; p_ve[pc] = v;
        p_r[pc] = r; p_g[pc] = g; p_b[pc] = b; p_hres[pc] = cur_hres;
        p_hs[pc] = 1'($urandom_range(1));
        p_full[pc] = ($urandom_range(99) < full_pct);
        if (!rst) begin
            st = S_IDLE;
            prev_vs = 1'b0;
        end else begin
            if (st == S_IDLE) begin
                if (cur_start) st = S_ARM;
            end else if (vs && !prev_vs) begin
                if (st == S_ARM) begin
                    e_go[pc + 1] = 1'b1;
                    st = S_FRAME;
                end else begin
                    e_done[pc + 1] = 1'b1;
                    st = cur_start ? S_ARM : S_IDLE;
                end
            end
            prev_vs = vs;
        end
        pc++;
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++)
            emit(1'b1, 1'b0, 1'b0, 8'($urandom_range(255)), 8'($urandom_range(255)), 8'($urandom_range(255)));
    endtask

    task automatic vpulse();
        emit(1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
        emit(1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
        gap(2);
    endtask

    task automatic add_push(input int d, input int p, input logic [31:0] w, input int k);
        e_try[d][p]  = 1'b1;
        e_data[d][p] = w;
        if (k % ((d == 1) ? CH4 : CH2) == 0) e_ch[d][p] = 1'b1;
    endtask

    // One ve burst of n cycles; push/marker timing follows from n and hres alone.
    task automatic line(input int n, input bit directed);
        logic [7:0] lr[64], lg[64], lb[64];
        int s, cap, hr;
        bit in_fr;
        s = pc; in_fr = (st == S_FRAME); hr = int'(cur_hres);
        for (int i = 0; i < n; i++) begin
            lr[i] = 8'($urandom_range(255)); lg[i] = 8'($urandom_range(255)); lb[i] = 8'($urandom_range(255));
            if (directed && i == 0) begin lr[i] = 8'hF0; lg[i] = 8'h20; lb[i] = 8'h10; end
            if (directed && i == 1) begin lr[i] = 8'hA0; lg[i] = 8'h70; lb[i] = 8'hF0; end
            emit(1'b1, 1'b0, 1'b1, lr[i], lg[i], lb[i]);
        end
        gap(3);
        if (in_fr) begin
            cap = (n < hr) ? n : hr;
            for (int i = 0; i < cap; i++)
                add_push(1, s + i + 1, {8'h00, lr[i], lg[i], lb[i]}, i + 1);
            for (int j = 0; j < cap / 2; j++)
                add_push(0, s + 2 * j + 2, {enc16(lr[2*j], lg[2*j], lb[2*j]),
                                            enc16(lr[2*j+1], lg[2*j+1], lb[2*j+1])}, j + 1);
            if (cap % 2 == 1)
                add_push(0, s + n + 1, {enc16(lr[cap-1], lg[cap-1], lb[cap-1]), 16'h0000}, cap / 2 + 1);
            if (cap > 0) begin
                e_nl[1][s + n + 1] = 1'b1;
                e_nl[0][s + n + 1 + cap % 2] = 1'b1;
            end
        end
    endtask

    task automatic build();
        logic [7:0] r, g, b;
        for (int c = 0; c < N; c++) begin
            p_rst[c] = 1'b1; p_start[c] = 0; p_vs[c] = 0; p_ve[c] = 0; p_full[c] = 0; p_hs[c] = 0;
            p_r[c] = 0; p_g[c] = 0; p_b[c] = 0; p_hres[c] = 0; e_go[c] = 0; e_done[c] = 0;
            for (int d = 0; d < 2; d++) begin
                e_try[d][c] = 0; e_wf[d][c] = 0; e_nl[d][c] = 0; e_ch[d][c] = 0; e_ov[d][c] = 0; e_data[d][c] = 0;
            end
        end
        pc = 0; st = S_IDLE; full_pct = 0; cur_start = 0; prev_vs = 0; cur_hres = 11'd4;
        for (int i = 0; i < 4; i++) emit(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        gap(3);
        line(5, 0);                       // idle: ignored
        cur_start = 1; gap(3);
        line(3, 0);                       // armed: ignored
        vpulse(); gap(2);                 // frame A, hres 4
        pin_a = pc; line(4, 1); line(6, 0);
        vpulse(); gap(3);
        cur_hres = 11'd3;                 // frame B, hres 3
        vpulse(); gap(2);
        pin_b = pc; line(3, 0); line(5, 0); line(2, 0);
        vpulse(); gap(3);
        cur_hres = 11'd40;                // frame C, 40-pixel line with 3 stalls
        vpulse(); gap(2);
        pin_40 = pc; line(40, 0);
        p_full[pin_40 + 5] = 1; p_full[pin_40 + 20] = 1; p_full[pin_40 + 33] = 1;
        line(17, 0);
        pin_cdone = pc + 1;
        vpulse(); gap(3);
        full_pct = 25;
        for (int f = 0; f < 4; f++) begin
            cur_hres = (f == 2) ? 11'd0 : 11'($urandom_range(50, 1));
            if (f == 0) pin_go = pc + 1;
            vpulse(); gap(2);
            for (int l = 0, nl = $urandom_range(4, 1); l < nl; l++) begin
                if (f == 1 && l == 0) cur_start = 0;
                line($urandom_range(60, 1), 0);
            end
            cur_start = (f != 3);
            vpulse(); gap(3);
        end
        full_pct = 0;
        vpulse(); gap(3);                 // idle, start low: no frame
        cur_start = 1; gap(3);
        vpulse(); gap(2);
        pin_rst = pc;                     // one pending pixel then reset
        r = 8'($urandom_range(255)); g = 8'($urandom_range(255)); b = 8'($urandom_range(255));
        emit(1'b1, 1'b0, 1'b1, r, g, b);
        emit(1'b0, 1'b0, 1'b1, 8'h11, 8'h22, 8'h33);
        add_push(1, pin_rst + 1, {8'h00, r, g, b}, 1);
        emit(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        emit(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        cur_start = 0; gap(4);
        vpulse(); gap(4);
        plan_len = pc;
        for (int c = 1; c < N; c++)
            for (int d = 0; d < 2; d++) begin
                e_wf[d][c] = e_try[d][c] && !p_full[c-1];
                e_ov[d][c] = p_rst[c-1] && ((e_try[d][c] && p_full[c-1]) || (e_ov[d][c-1] && !e_go[c]));
            end
    endtask

    task automatic chk(input string name, input int cyc, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, want);
        end
    endtask

    initial begin
        reset = 0; start = 0; hsync = 0; vsync = 0; ve = 0; fifo_full = 0;
        hres = 0; red = 0; green = 0; blue = 0; built = 0;
        build();
        built = 1;
        for (int c = 0; c < plan_len; c++) begin
            @(posedge clock); #1;
            reset = p_rst[c]; start = p_start[c]; vsync = p_vs[c]; ve = p_ve[c];
            fifo_full = p_full[c]; hsync = p_hs[c]; hres = p_hres[c];
            red = p_r[c]; green = p_g[c]; blue = p_b[c];
        end
    end

    initial begin
        int w4, n4;
        w4 = 0; n4 = 0;
        wait (built);
        for (int c = 0; c < plan_len; c++) begin
            @(negedge clock);
            if (c > 0) begin
                for (int d = 0; d < 2; d++) begin
                    chk(d ? "wf4" : "wf2", c, d ? wf4 : wf2, e_wf[d][c]);
                    if (e_wf[d][c]) chk(d ? "data4" : "data2", c, d ? data4 : data2, e_data[d][c]);
                    chk(d ? "line4" : "line2", c, d ? nl4 : nl2, e_nl[d][c]);
                    chk(d ? "chunk4" : "chunk2", c, d ? ch4 : ch2, e_ch[d][c]);
                    chk(d ? "go4" : "go2", c, d ? go4 : go2, e_go[c]);
                    chk(d ? "done4" : "done2", c, d ? dn4 : dn2, e_done[c]);
                    chk(d ? "ovf4" : "ovf2", c, d ? ov4 : ov2, e_ov[d][c]);
                    if (!p_rst[c-1]) chk(d ? "rst_data4" : "rst_data2", c, d ? data4 : data2, 32'h0);
                end
                if (c == pin_a + 2) chk("pin_pair_word", c, data2, 32'hF102A39E);
                if (c == pin_b + 4) begin
                    chk("pin_flush_push", c, wf2, 32'd1);
                    chk("pin_flush_low", c, {16'h0, data2[15:0]}, 32'h0);
                end
                if (c == pin_b + 5) chk("pin_flush_line", c, nl2, 32'd1);
                if (c > pin_40 && c <= pin_40 + 40) begin
                    w4 += wf4;
                    n4 += ch4;
                end
                if (c == pin_40 + 41) begin
                    chk("pin_40_writes", c, w4, 32'd37);
                    chk("pin_40_chunks", c, n4, 32'd2);
                end
                if (c == pin_cdone) chk("pin_ovf_held", c, ov4, 32'd1);
                if (c == pin_go) chk("pin_ovf_clear", c, ov4, 32'd0);
                if (c == pin_rst + 2)
                    chk("pin_rst_quiet", c, {wf2, wf4, nl2, nl4, ch2, ch4, go2, go4, dn2, dn4, ov2, ov4}, 32'd0);
            end
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
